// File: rtl/rd_resp_packer.sv
// rtl/rd_resp_packer.sv - packs 32-bit read words into 64-bit beats behind an output FIFO
module rd_resp_packer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_valid_i,
   input  logic [31:0]      rd_data_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [63:0]      out_data_o,
   output logic             out_half_o,
   output logic             overflow_o,
   input  logic             clear_ovf_i,
   output logic [CNT_W-1:0] word_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_HALF  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        hold_q, hold_d;
   logic [64:0]        mem_q [DEPTH];
   logic [64:0]        mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [63:0]        out_data_q, out_data_d;
   logic               out_half_q, out_half_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

   logic               push;
   logic [63:0]        beat_data;
   logic               beat_half;
   logic               pop;
   logic               full;
   logic               accept;

   // Pairing state machine: decides whether this cycle produces a beat and what it holds
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      push      = 1'b0;
      beat_data = 64'h0;
      beat_half = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (rd_valid_i) begin
               if (flush_i) begin
                  push      = 1'b1;
                  beat_data = {32'h0, rd_data_i};
                  beat_half = 1'b1;
               end else begin
                  hold_d  = rd_data_i;
                  state_d = S_HALF;
               end
            end
         end
         S_HALF: begin
            if (rd_valid_i) begin
               push      = 1'b1;
               beat_data = {rd_data_i, hold_q};
               state_d   = S_EMPTY;
            end else if (flush_i) begin
               push      = 1'b1;
               beat_data = {32'h0, hold_q};
               beat_half = 1'b1;
               state_d   = S_EMPTY;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Queue bookkeeping; the next head is precomputed so the outputs come straight from flops
   always_comb begin
      pop    = out_valid_q & out_ready_i;
      full   = (count_q == CNT_FULL);
      accept = push & (~full | pop);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (accept) begin
         mem_d[wr_ptr_q] = {beat_half, beat_data};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (accept && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !accept) begin
         count_d = count_q - CNT_ONE;
      end

      out_valid_d = (count_d != '0);
      if (out_valid_d) begin
         {out_half_d, out_data_d} = mem_d[rd_ptr_d];
      end else begin
         out_half_d = 1'b0;
         out_data_d = 64'h0;
      end

      // A dropped beat sets the flag; setting beats clearing in the same cycle
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end else if (clear_ovf_i) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end

      word_cnt_d = rd_valid_i ? word_cnt_q + CNT_W'(1) : word_cnt_q;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_EMPTY;
         hold_q      <= 32'h0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 65'h0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 64'h0;
         out_half_q  <= 1'b0;
         overflow_q  <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_half_q  <= out_half_d;
         overflow_q  <= overflow_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_half_o  = out_half_q;
   assign overflow_o  = overflow_q;
   assign word_cnt_o  = word_cnt_q;

endmodule

// File: doc/rd_resp_packer.md
RD_RESP_PACKER -- requirements
Module: rd_resp_packer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 4, output queue entries; power of two, at least 2.
- CNT_W, 16, width of word_cnt_o.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-low reset.
- rd_valid_i, in, 1, one-cycle pulse marking a completed APB read word; no backpressure is possible.
- rd_data_i, in, 32, read word; sampled only when rd_valid_i=1.
- flush_i, in, 1, emit any pending half-pair as a partial beat.
- out_valid_o, out, 1, queue head is valid.
- out_ready_i, in, 1, consumer accepts the head.
- out_data_o, out, 64, packed beat: {second word, first word}.
- out_half_o, out, 1, 1 means only out_data_o[31:0] is meaningful and [63:32]=0.
- overflow_o, out, 1, sticky flag: a beat was dropped because the queue was full.
- clear_ovf_i, in, 1, clears overflow_o.
- word_cnt_o, out, CNT_W, count of rd_valid_i pulses received; wraps modulo 2^CNT_W.

Function
REQ-003 The packer SHALL have two states: EMPTY (no held word) and HALF (one word held in hold_q).
- EMPTY, rd_valid_i, no flush_i: capture rd_data_i into hold_q; go to HALF.
- HALF, rd_valid_i: form beat {rd_data_i, hold_q} with half=0; push it; go to EMPTY.
- HALF, flush_i, no rd_valid_i: form beat {32'h0, hold_q} with half=1; push it; go to EMPTY.
- EMPTY, rd_valid_i and flush_i together: form beat {32'h0, rd_data_i} with half=1; push it; stay in EMPTY.
- HALF, rd_valid_i and flush_i together: complete the full pair as in the HALF/rd_valid_i rule; flush_i has no further effect.
- EMPTY, flush_i alone: no operation.
REQ-004 The output queue SHALL be a FIFO of DEPTH entries, each 65 bits (data plus half flag).
- out_valid_o = queue not empty; out_data_o and out_half_o present the head.
- Head and outputs are registered.
- Head SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-005 Pop SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-006 Latency: a beat pushed in cycle N into an empty queue SHALL appear on out_valid_o in cycle N+1.
REQ-007 Push and pop in the same cycle SHALL both take effect, including when the queue is full; occupancy is unchanged.
REQ-008 Push into a full queue with no simultaneous pop:
- the beat is dropped, including any held word it contains;
- overflow_o is set;
- the packer state still advances per REQ-003.
REQ-009 overflow_o SHALL clear on clear_ovf_i. If set and clear occur in the same cycle, set wins.
REQ-010 word_cnt_o SHALL increment by 1 on every rd_valid_i, including words later dropped, and SHALL wrap from all-ones to 0.
REQ-011 Queue read and write pointers SHALL wrap modulo DEPTH. Full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter of width log2(DEPTH)+1.

Reset
REQ-012 While reset=0 at a clock edge, all of the following SHALL be 0 after that edge:
- state=EMPTY, hold_q, queue pointers and occupancy;
- out_valid_o, out_data_o, out_half_o, overflow_o, word_cnt_o.
REQ-013 Reset asserted mid-operation SHALL discard the held word and all queued beats without emitting them; inputs are ignored during reset.

Verification
REQ-014 Pair packing: rd pulses with 32'hAAAA0001 then 32'hBBBB0002, out_ready_i=1 -> one beat 64'hBBBB0002_AAAA0001, out_half_o=0, word_cnt_o=2.
REQ-015 Flush: one pulse with 32'h12345678, then flush_i for 1 cycle -> beat 64'h00000000_12345678, out_half_o=1, state EMPTY.
REQ-016 Overflow: out_ready_i=0, 10 pulses (DEPTH=4) -> 4 beats held, 5th pair dropped, overflow_o=1, word_cnt_o=10; then clear_ovf_i -> overflow_o=0; then draining delivers the first 4 beats in order.
REQ-017 Full with simultaneous push and pop: queue full, out_ready_i=1 in the same cycle a pair completes -> occupancy stays 4, overflow_o stays 0, no beat lost.
REQ-018 Reset mid-operation: hold one word plus 2 queued beats, then reset=0 for 1 cycle -> out_valid_o=0, word_cnt_o=0, next pulse is treated as a first word.
REQ-019 Counter wrap: preload by 65535 pulses, then one more -> word_cnt_o=0.
